// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the chunked pipelined adder.
// Every file that instantiates or sizes the adder imports this package.
package pipelined_adder_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultChunk = 8;

  // True when the operand width splits into a whole number (>= 1) of slices.
  function automatic bit chunk_aligned(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Clamped to 1 so a bad parameter set still elaborates far enough to hit the width check.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    int unsigned stages;
    stages = (chunk == 0) ? 1 : width / chunk;
    return (stages == 0) ? 1 : stages;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of every ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_adder_chunk.sv
// Purely combinational WIDTH-bit ripple adder built from full_adder cells.
// One instance sums one slice per pipeline stage.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultChunk
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Each bit owns its carry net so the chain is not one self-dependent vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_link
      assign ci = g_bit[i-1].co;
    end

    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, valid/ready stream with a single global stall.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
  localparam int unsigned Last   = STAGES - 1;

  if (!chunk_aligned(WIDTH, CHUNK)) begin : g_width_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic                         advance;
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            valid_in;
  logic [STAGES-1:0]            carry_in;
  logic [STAGES-1:0]            carry_out;
  logic [STAGES-1:0]            carry_q;
  logic [STAGES-1:0][WIDTH-1:0] op_a;
  logic [STAGES-1:0][WIDTH-1:0] op_b;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_in;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [STAGES-1:0][CHUNK-1:0] slice_sum;
  logic                         ovf_d;
  logic                         ovf_q;

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  assign advance  = ~valid_q[Last] | out_ready;
  assign in_ready = advance;

  // Stage inputs. B is inverted once at entry, so the skew registers carry b_eff.
  always_comb begin
    valid_in    = '0;
    carry_in    = '0;
    op_a        = '0;
    op_b        = '0;
    sum_in      = '0;
    valid_in[0] = in_valid;
    carry_in[0] = in_sub;
    op_a[0]     = in_a;
    op_b[0]     = in_sub ? ~in_b : in_b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_in[k] = valid_q[k-1];
      carry_in[k] = carry_q[k-1];
      op_a[k]     = a_q[k-1];
      op_b[k]     = b_q[k-1];
      sum_in[k]   = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(
      .WIDTH (CHUNK)
    ) u_chunk (
      .a    (op_a[k][k*CHUNK +: CHUNK]),
      .b    (op_b[k][k*CHUNK +: CHUNK]),
      .cin  (carry_in[k]),
      .sum  (slice_sum[k]),
      .cout (carry_out[k])
    );
  end

  // Deskew: lower slices ride along, the freshly computed slice is dropped into place.
  always_comb begin
    sum_d = sum_in;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum_d[k][k*CHUNK +: CHUNK] = slice_sum[k];
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_d = (op_a[Last][WIDTH-1] == op_b[Last][WIDTH-1]) &&
                 (slice_sum[Last][CHUNK-1] != op_a[Last][WIDTH-1]);

  // Data registers load only behind a valid beat, so outputs hold across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_in;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (valid_in[k]) begin
          carry_q[k] <= carry_out[k];
          a_q[k]     <= op_a[k];
          b_q[k]     <= op_b[k];
          sum_q[k]   <= sum_d[k];
        end
      end
      if (valid_in[Last]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign out_sum   = sum_q[Last];
  assign out_carry = carry_q[Last];
  assign out_ovf   = ovf_q;

  // Already-consumed low operand slices and the final skew stage are never read.
  logic unused_skew;
  assign unused_skew = ^{op_a, op_b, a_q[Last], b_q[Last]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 32/8 instance and an 8/8 single-stage instance.
module tb_pipelined_adder;

  localparam int unsigned Lat32 = 3;
  localparam int unsigned Lat8  = 0;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_carry, out_ovf;
  logic [31:0] in_a, in_b, out_sum;
  logic        in_valid8, in_ready8, in_sub8, out_valid8, out_ready8, out_carry8, out_ovf8;
  logic [7:0]  in_a8, in_b8, out_sum8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic        held_valid, held_valid8;
  logic [33:0] held_data;
  logic [9:0]  held_data8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  pipelined_adder #(
    .WIDTH (8),
    .CHUNK (8)
  ) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .in_sub    (in_sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_sum   (out_sum8),
    .out_carry (out_carry8),
    .out_ovf   (out_ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input bit lat);
    exp_t e;
    e.sum     = s;
    e.carry   = c;
    e.ovf     = o;
    e.acc     = 0;
    e.chk_lat = lat;
    return e;
  endfunction

  // Reference: A + ~B + 1 for subtract, at 33 bits.
  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] beff;
    logic [32:0] full;
    exp_t        e;
    beff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {32'd0, sub};
    e = mk(full[31:0], full[32], (a[31] == beff[31]) && (full[31] != a[31]), 1'b0);
    return e;
  endfunction

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc + 1;
        q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout32", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub, input exp_t e);
    bit done = 1'b0;
    in_valid8 = 1'b1;
    in_a8     = a;
    in_b8     = b;
    in_sub8   = sub;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (in_ready8) begin
        e.acc = cyc + 1;
        q8.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout8", 32'd0, 32'd1);
    in_valid8 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (q32.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    #1;
    check("drain", 32'(q32.size() + q8.size()), 32'd0);
  endtask

  // Output monitors: compare on each transfer, and check hold/backpressure while stalled.
  always @(negedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
    end else begin
      if (out_valid && held_valid)
        check("hold32", 32'({out_sum, out_carry, out_ovf}), 32'(held_data));
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      held_valid <= out_valid && !out_ready;
      held_data  <= {out_sum, out_carry, out_ovf};
      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          check("unexpected_beat32", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q32.pop_front();
          check("sum32", out_sum, e.sum);
          check("carry32", 32'(out_carry), 32'(e.carry));
          check("ovf32", 32'(out_ovf), 32'(e.ovf));
          if (e.chk_lat) check("latency32", 32'(cyc - e.acc), Lat32);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held_valid8 <= 1'b0;
    end else begin
      if (out_valid8 && held_valid8)
        check("hold8", 32'({out_sum8, out_carry8, out_ovf8}), 32'(held_data8));
      held_valid8 <= out_valid8 && !out_ready8;
      held_data8  <= {out_sum8, out_carry8, out_ovf8};
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          check("unexpected_beat8", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("sum8", 32'(out_sum8), e.sum);
          check("carry8", 32'(out_carry8), 32'(e.carry));
          check("ovf8", 32'(out_ovf8), 32'(e.ovf));
          if (e.chk_lat) check("latency8", 32'(cyc - e.acc), Lat8);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {in_valid, in_sub, in_a, in_b} = '0;
    {in_valid8, in_sub8, in_a8, in_b8} = '0;
    out_ready  = 1'b1;
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_flags", 32'({out_carry, out_ovf}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases, back to back, no stall: latency is checked exactly.
    send32(32'h0000_0002, 32'h0000_0002, 1'b0, mk(32'h0000_0004, 1'b0, 1'b0, 1'b1));
    send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b1));
    send32(32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1));
    send32(32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1));
    send8(8'h92, 8'hAB, 1'b0, mk(32'h0000_003D, 1'b1, 1'b1, 1'b1));
    send8(8'h10, 8'h20, 1'b1, mk(32'h0000_00F0, 1'b0, 1'b0, 1'b1));
    wait_drain();

    // Random stream with a 3-cycle output stall while the pipe is full.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] a, b;
          logic        s;
          a = $urandom();
          b = $urandom();
          s = 1'($urandom_range(0, 1));
          send32(a, b, s, model32(a, b, s));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_blocks_input", 32'({out_valid, in_ready}), 32'b10);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with beats in flight on both instances.
    out_ready8 = 1'b0;
    send8(8'h01, 8'h01, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom() | 32'h1;
      b = $urandom();
      send32(a, b, 1'b0, model32(a, b, 1'b0));
    end
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", out_sum, 32'd0);
    check("mid_rst_flags", 32'({out_carry, out_ovf}), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid8", 32'(out_valid8), 32'd0);
    check("mid_rst_out_sum8", 32'(out_sum8), 32'd0);
    q32.delete();
    q8.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'({out_valid, out_valid8}), 32'd0);
    end
    @(posedge clk);
    #1;
    send32(32'h0000_0010, 32'h0000_0020, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b1));
    send8(8'h7F, 8'h01, 1'b0, mk(32'h0000_0080, 1'b0, 1'b1, 1'b1));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
